// File: rtl/mux_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_ser_pkg
//  Description : Shared types and constants for the 8:1 mux serial sequencer.
//                Bit order is set at compile time by MUX_SER_MSB_FIRST_EN:
//                  undefined -> select runs 0..7 (LSB first)
//                  defined   -> select runs 7..0 (MSB first)
//  Revision    : 1.0  initial release
// ============================================================================
package mux_ser_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef MUX_SER_MSB_FIRST_EN
    localparam logic [SEL_W-1:0] FIRST_SEL = 3'd7;
    localparam logic [SEL_W-1:0] LAST_SEL  = 3'd0;

    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
        return sel - 3'd1;
    endfunction
`else
    localparam logic [SEL_W-1:0] FIRST_SEL = 3'd0;
    localparam logic [SEL_W-1:0] LAST_SEL  = 3'd7;

    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
        return sel + 3'd1;
    endfunction
`endif

endpackage : mux_ser_pkg
`default_nettype wire

// File: rtl/mux_ser_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_ser_bit_timer
//  Description : Per-bit hold counter. Counts 0..BIT_CYCLES-1 while enabled,
//                wrapping to 0 after the terminal count; clear forces 0.
//  Ports       : clk, rst   - clock, async active-high reset
//                en_i       - advance the counter this cycle
//                clr_i      - synchronous clear (wins over en_i)
//                tc_o       - counter is at BIT_CYCLES-1
//  Revision    : 1.0  initial release
// ============================================================================
module mux_ser_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    // At least one bit wide so BIT_CYCLES = 1 still yields a legal vector.
    localparam int               CNT_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cyc_cnt_q;
    logic [CNT_W-1:0] cyc_cnt_d;

    assign tc_o = (cyc_cnt_q == CNT_LAST);

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (clr_i) begin
            cyc_cnt_d = '0;
        end else if (en_i) begin
            cyc_cnt_d = tc_o ? '0 : cyc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

endmodule : mux_ser_bit_timer
`default_nettype wire

// File: rtl/mux_ser_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_ser_sequencer
//  Description : Accepts an 8-bit word over valid/ready, drives it onto the
//                data inputs of an external 8:1 mux and walks the mux select
//                through all eight positions, BIT_CYCLES clocks per bit, so
//                the mux output is a qualified serial bitstream.
//                Compile option: MUX_SER_MSB_FIRST_EN selects MSB-first order.
//  Ports       : clk, rst          - clock, async active-high reset
//                in_data_i/valid_i - input word handshake; in_ready_o out
//                mux_d_o, mux_s_o  - registered mux data / select
//                bit_valid_o       - mux output carries a frame bit
//                bit_first_o/last_o- first / last bit of the frame
//                bit_ready_i       - downstream ready; low stalls the block
//  Revision    : 1.0  initial release
// ============================================================================
module mux_ser_sequencer
    import mux_ser_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [WORD_W-1:0] mux_d_o,
    output logic [SEL_W-1:0]  mux_s_o,
    output logic              bit_valid_o,
    output logic              bit_first_o,
    output logic              bit_last_o,
    input  logic              bit_ready_i
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] mux_d_q, mux_d_d;
    logic [SEL_W-1:0]  mux_s_q, mux_s_d;

    logic w_tc;
    logic w_shift;
    logic w_bit_end;
    logic w_term;
    logic w_accept;

    assign w_shift   = (state_q == ST_SHIFT);
    assign w_bit_end = w_shift & bit_ready_i & w_tc;
    // Terminal cycle: last clock of the last bit, consumed downstream.
    assign w_term    = w_bit_end & (mux_s_q == LAST_SEL);

    // Ready in IDLE, and on the terminal cycle so frames can chain gap-free.
    assign in_ready_o = ~rst & ((state_q == ST_IDLE) | w_term);
    assign w_accept   = in_valid_i & in_ready_o;

    mux_ser_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .en_i  (w_shift & bit_ready_i),
        .clr_i (w_accept),
        .tc_o  (w_tc)
    );

    always_comb begin
        state_d = state_q;
        mux_d_d = mux_d_q;
        mux_s_d = mux_s_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    mux_d_d = in_data_i;
                    mux_s_d = FIRST_SEL;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_term) begin
                    if (w_accept) begin
                        mux_d_d = in_data_i;
                        mux_s_d = FIRST_SEL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (w_bit_end) begin
                    mux_s_d = next_sel(mux_s_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mux_d_q <= '0;
            mux_s_q <= '0;
        end else begin
            state_q <= state_d;
            mux_d_q <= mux_d_d;
            mux_s_q <= mux_s_d;
        end
    end

    assign mux_d_o     = mux_d_q;
    assign mux_s_o     = mux_s_q;
    assign bit_valid_o = w_shift;
    assign bit_first_o = w_shift & (mux_s_q == FIRST_SEL);
    assign bit_last_o  = w_shift & (mux_s_q == LAST_SEL);

endmodule : mux_ser_sequencer
`default_nettype wire

// File: tb/tb_mux_ser_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_ser_sequencer
//  Description : Directed self-checking bench. Instance A uses BIT_CYCLES=4,
//                instance B uses BIT_CYCLES=1. Serial bit is modelled as the
//                external mux: mux_d[mux_s].
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_ser_sequencer;

    localparam int A_BC = 4;
    localparam int B_BC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] a_in_data  = 8'h00;
    logic       a_in_valid = 1'b0;
    logic       a_bit_ready = 1'b1;
    logic       a_in_ready, a_bit_valid, a_bit_first, a_bit_last;
    logic [7:0] a_mux_d;
    logic [2:0] a_mux_s;

    logic [7:0] b_in_data  = 8'h00;
    logic       b_in_valid = 1'b0;
    logic       b_bit_ready = 1'b1;
    logic       b_in_ready, b_bit_valid, b_bit_first, b_bit_last;
    logic [7:0] b_mux_d;
    logic [2:0] b_mux_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_ser_sequencer #(.BIT_CYCLES(A_BC)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (a_in_data),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .mux_d_o     (a_mux_d),
        .mux_s_o     (a_mux_s),
        .bit_valid_o (a_bit_valid),
        .bit_first_o (a_bit_first),
        .bit_last_o  (a_bit_last),
        .bit_ready_i (a_bit_ready)
    );

    mux_ser_sequencer #(.BIT_CYCLES(B_BC)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (b_in_data),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .mux_d_o     (b_mux_d),
        .mux_s_o     (b_mux_s),
        .bit_valid_o (b_bit_valid),
        .bit_first_o (b_bit_first),
        .bit_last_o  (b_bit_last),
        .bit_ready_i (b_bit_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Select used for frame bit i
    function automatic int order(input int i);
`ifdef MUX_SER_MSB_FIRST_EN
        return 7 - i;
`else
        return i;
`endif
    endfunction

    // Present a word to instance A and let it be accepted at the next edge.
    task automatic send_a(input logic [7:0] w, input logic keep_valid);
        a_in_data  = w;
        a_in_valid = 1'b1;
        #1;
        check_eq("a_acc_rdy", a_in_ready, 1'b1);
        tick();
        a_in_valid = keep_valid;
    endtask

    // Walk one frame on instance A. Optional stall of stall_len cycles at the
    // start of frame cycle stall_at. A word pending on in_data/in_valid is
    // accepted only on the final cycle.
    task automatic run_frame_a(input logic [7:0] w, input int stall_at, input int stall_len);
        int sel;
        int acc;
        acc = 0;
        for (int k = 0; k < 8 * A_BC; k++) begin
            sel = order(k / A_BC);
            if (k == stall_at) begin
                a_bit_ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    #1;
                    check_eq("stall_sel",   a_mux_s, sel);
                    check_eq("stall_data",  a_mux_d, w);
                    check_eq("stall_rdy",   a_in_ready, 1'b0);
                    check_eq("stall_valid", a_bit_valid, 1'b1);
                    tick();
                end
                a_bit_ready = 1'b1;
            end
            #1;
            check_eq("f_valid", a_bit_valid, 1'b1);
            check_eq("f_data",  a_mux_d, w);
            check_eq("f_sel",   a_mux_s, sel);
            check_eq("f_ser",   a_mux_d[a_mux_s], w[sel]);
            check_eq("f_first", a_bit_first, (k < A_BC));
            check_eq("f_last",  a_bit_last, (k >= 7 * A_BC));
            check_eq("f_rdy",   a_in_ready, (k == 8 * A_BC - 1));
            if (a_in_valid && a_in_ready) acc++;
            tick();
        end
        check_eq("f_acc", acc, a_in_valid ? 1 : 0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rdy",   a_in_ready, 1'b0);
        check_eq("rst_d",     a_mux_d, 8'h00);
        check_eq("rst_s",     a_mux_s, 3'd0);
        check_eq("rst_valid", a_bit_valid, 1'b0);
        check_eq("rst_first", a_bit_first, 1'b0);
        check_eq("rst_last",  a_bit_last, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("idle_rdy",   a_in_ready, 1'b1);
        check_eq("idle_rdy_b", b_in_ready, 1'b1);
        tick();

        // Basic frame 8'hA5
        send_a(8'hA5, 1'b0);
        run_frame_a(8'hA5, -1, 0);
        #1;
        check_eq("a5_end_valid", a_bit_valid, 1'b0);
        check_eq("a5_end_rdy",   a_in_ready, 1'b1);
        check_eq("a5_end_d",     a_mux_d, 8'hA5);

        // Single set bit: order visible directly on the serial line
        send_a(8'h01, 1'b0);
        run_frame_a(8'h01, -1, 0);
        #1;
        check_eq("01_end_valid", a_bit_valid, 1'b0);

        // Back-to-back FF then 00 with in_valid held high
        send_a(8'hFF, 1'b1);
        a_in_data = 8'h00;
        run_frame_a(8'hFF, -1, 0);
        a_in_valid = 1'b0;
        #1;
        check_eq("b2b_valid", a_bit_valid, 1'b1);
        check_eq("b2b_d",     a_mux_d, 8'h00);
        check_eq("b2b_first", a_bit_first, 1'b1);
        run_frame_a(8'h00, -1, 0);
        #1;
        check_eq("b2b_end_valid", a_bit_valid, 1'b0);

        // Stall for 5 cycles in the middle of bit 3
        send_a(8'h96, 1'b0);
        run_frame_a(8'h96, 3 * A_BC + 1, 5);
        #1;
        check_eq("stall_end_valid", a_bit_valid, 1'b0);
        check_eq("stall_end_rdy",   a_in_ready, 1'b1);

        // Single-cycle bits on instance B
        b_in_data  = 8'h3C;
        b_in_valid = 1'b1;
        #1;
        check_eq("b_acc_rdy", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq("b_valid", b_bit_valid, 1'b1);
            check_eq("b_sel",   b_mux_s, order(k));
            check_eq("b_ser",   b_mux_d[b_mux_s], 1'((8'h3C >> order(k)) & 8'h01));
            check_eq("b_first", b_bit_first, (k == 0));
            check_eq("b_last",  b_bit_last, (k == 7));
            check_eq("b_rdy",   b_in_ready, (k == 7));
            tick();
        end
        #1;
        check_eq("b_end_valid", b_bit_valid, 1'b0);

        // Reset in the middle of a frame: outputs clear immediately
        send_a(8'hC3, 1'b0);
        repeat (6) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("mrst_d",     a_mux_d, 8'h00);
        check_eq("mrst_s",     a_mux_s, 3'd0);
        check_eq("mrst_valid", a_bit_valid, 1'b0);
        check_eq("mrst_first", a_bit_first, 1'b0);
        check_eq("mrst_last",  a_bit_last, 1'b0);
        check_eq("mrst_rdy",   a_in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("mrst_idle_rdy", a_in_ready, 1'b1);
        tick();
        check_eq("mrst_idle_valid", a_bit_valid, 1'b0);
        check_eq("mrst_idle_d",     a_mux_d, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_ser_sequencer
`default_nettype wire
